// File: rtl/serial_link_credit_sync_mc.sv
// Per-VC credit gate between the tx arbiter and the packetiser; piggybacks returned credits, injects credit-only beats.
// Latency 1 cycle (registered beat); tx_ready drops when the output is held or the VC lacks credit.
module serial_link_credit_sync_mc #(
  parameter int NumChannels     = 2,
  parameter int NumCredits      = 8,
  parameter int ForceSendThresh = NumCredits - 4,
  parameter int DataWidth       = 64,
  localparam int ChanW          = (NumChannels > 1) ? $clog2(NumChannels) : 1,
  localparam int CreditW        = $clog2(NumCredits + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [DataWidth-1:0]           tx_data_i,
  input  logic [ChanW-1:0]               tx_chan_i,
  input  logic                           tx_valid_i,
  output logic                           tx_ready_o,
  output logic [DataWidth-1:0]           link_data_o,
  output logic [ChanW-1:0]               link_chan_o,
  output logic [CreditW-1:0]             link_credit_o,
  output logic [ChanW-1:0]               link_credit_chan_o,
  output logic                           link_credit_only_o,
  output logic                           link_valid_o,
  input  logic                           link_ready_i,
  input  logic [CreditW-1:0]             rx_credit_i,
  input  logic [ChanW-1:0]               rx_credit_chan_i,
  input  logic                           rx_credit_valid_i,
  input  logic [NumChannels-1:0]         rx_consume_i,
  output logic [NumChannels*CreditW-1:0] credits_available_o
);

  typedef struct packed {
    logic [DataWidth-1:0] dat;
    logic [ChanW-1:0]     chan;
    logic [CreditW-1:0]   credit;
    logic [ChanW-1:0]     credit_chan;
    logic                 only;
  } beat_t;

  beat_t              beat_q, beat_d;
  logic               beat_vld_q;
  logic [CreditW-1:0] avail_q   [NumChannels];
  logic [CreditW-1:0] pending_q [NumChannels];
  logic [ChanW-1:0]   rr_q;

  logic               out_free;
  logic [ChanW-1:0]   sel;
  logic [ChanW-1:0]   next_rr;
  logic [CreditW-1:0] sel_credit;
  logic [CreditW-1:0] tx_avail;
  logic               eligible;
  logic               force_any;
  logic               data_load;
  logic               force_load;
  logic               load;
  int                 idx;
  logic               found;

  assign out_free = ~beat_vld_q | link_ready_i;

  // Round-robin search for the first channel with credits to return, starting at rr.
  always_comb begin
    sel   = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NumChannels; i++) begin
      idx = (int'(rr_q) + i) % NumChannels;
      if (!found && pending_q[idx] != '0) begin
        sel   = ChanW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    force_any = 1'b0;
    for (int c = 0; c < NumChannels; c++) begin
      if (pending_q[c] >= CreditW'(ForceSendThresh)) force_any = 1'b1;
    end
  end

  assign sel_credit = pending_q[sel];
  assign next_rr    = (sel == ChanW'(NumChannels - 1)) ? '0 : sel + ChanW'(1);
  assign tx_avail   = avail_q[tx_chan_i];

  // The last remote credit is only spent on a beat that also returns credit, so both ends can't starve.
  assign eligible   = (tx_avail >= CreditW'(2)) ||
                      ((tx_avail == CreditW'(1)) && (sel_credit != '0));
  assign tx_ready_o = out_free & eligible;
  assign data_load  = tx_valid_i & tx_ready_o;
  assign force_load = ~data_load & out_free & force_any;
  assign load       = data_load | force_load;

  always_comb begin
    beat_d.dat         = data_load ? tx_data_i : '0;
    beat_d.chan        = data_load ? tx_chan_i : '0;
    beat_d.credit      = sel_credit;
    beat_d.credit_chan = sel;
    beat_d.only        = ~data_load;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q     <= '0;
      beat_vld_q <= 1'b0;
      rr_q       <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        avail_q[c]   <= CreditW'(NumCredits);
        pending_q[c] <= '0;
      end
    end else begin
      if (load) begin
        beat_q     <= beat_d;
        beat_vld_q <= 1'b1;
      end else if (link_ready_i) begin
        beat_vld_q <= 1'b0;
      end
      if (load && sel_credit != '0) rr_q <= next_rr;
      for (int c = 0; c < NumChannels; c++) begin
        pending_q[c] <= pending_q[c]
                        - ((load && sel == ChanW'(c)) ? sel_credit : '0)
                        + CreditW'(rx_consume_i[c]);
        avail_q[c]   <= avail_q[c]
                        - CreditW'(data_load && tx_chan_i == ChanW'(c))
                        + ((rx_credit_valid_i && rx_credit_chan_i == ChanW'(c)) ? rx_credit_i : '0);
      end
    end
  end

  assign link_data_o        = beat_q.dat;
  assign link_chan_o        = beat_q.chan;
  assign link_credit_o      = beat_q.credit;
  assign link_credit_chan_o = beat_q.credit_chan;
  assign link_credit_only_o = beat_q.only;
  assign link_valid_o       = beat_vld_q;

  for (genvar g = 0; g < NumChannels; g++) begin : g_lane
    assign credits_available_o[g*CreditW +: CreditW] = avail_q[g];

    assert property (@(posedge clk_i) disable iff (rst_i) avail_q[g] <= CreditW'(NumCredits));
    assert property (@(posedge clk_i) disable iff (rst_i) pending_q[g] <= CreditW'(NumCredits));
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
    rx_credit_valid_i |-> ({1'b0, avail_q[rx_credit_chan_i]} + {1'b0, rx_credit_i})
                          <= (CreditW + 1)'(NumCredits));

endmodule

// File: tb/tb_serial_link_credit_sync_mc.sv
// Bench for serial_link_credit_sync_mc: directed scenarios with literal expectations, then random traffic vs a behavioural model.
module tb_serial_link_credit_sync_mc;
  localparam int NCH   = 2;
  localparam int NCRED = 8;
  localparam int THR   = NCRED - 4;
  localparam int DW    = 64;
  localparam int CHW   = 1;
  localparam int CW    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   tx_data;
  logic [CHW-1:0]  tx_chan;
  logic            tx_valid;
  logic            tx_ready;
  logic [DW-1:0]   link_data;
  logic [CHW-1:0]  link_chan;
  logic [CW-1:0]   link_credit;
  logic [CHW-1:0]  link_credit_chan;
  logic            link_credit_only;
  logic            link_valid;
  logic            link_ready;
  logic [CW-1:0]   rx_credit;
  logic [CHW-1:0]  rx_credit_chan;
  logic            rx_credit_valid;
  logic [NCH-1:0]  rx_consume;
  logic [NCH*CW-1:0] credits_available;

  serial_link_credit_sync_mc #(
    .NumChannels(NCH), .NumCredits(NCRED), .ForceSendThresh(THR), .DataWidth(DW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .tx_data_i(tx_data), .tx_chan_i(tx_chan), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .link_data_o(link_data), .link_chan_o(link_chan), .link_credit_o(link_credit),
    .link_credit_chan_o(link_credit_chan), .link_credit_only_o(link_credit_only),
    .link_valid_o(link_valid), .link_ready_i(link_ready),
    .rx_credit_i(rx_credit), .rx_credit_chan_i(rx_credit_chan), .rx_credit_valid_i(rx_credit_valid),
    .rx_consume_i(rx_consume), .credits_available_o(credits_available)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: credit counters per channel plus the beat the link should currently present.
  bit          m_ok = 0;
  int          m_avail [NCH];
  int          m_pend  [NCH];
  int          m_owed  [NCH];
  int          m_rr;
  bit          m_vld;
  logic [63:0] m_data;
  int          m_chan, m_cred, m_cchan;
  bit          m_only;
  bit          g_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int lane(input int c);
    return int'(credits_available[c*CW +: CW]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_avail[c] = NCRED;
      m_pend[c]  = 0;
      m_owed[c]  = 0;
    end
    m_rr = 0; m_vld = 0;
  endtask

  // One clock: compare DUT against the model mid-cycle, advance the model, then move to just past the edge.
  task automatic step();
    int  sel, cred, tc, have;
    bit  free, elig, rdy, dl, fl, frc, found;
    #2;
    free  = !m_vld || link_ready;
    sel   = m_rr;
    found = 0;
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (m_rr + i) % NCH;
      if (!found && m_pend[c] != 0) begin sel = c; found = 1; end
    end
    cred = m_pend[sel];
    tc   = int'(tx_chan);
    have = m_avail[tc];
    elig = (have >= 2) || (have == 1 && cred != 0);
    rdy  = free && elig;
    dl   = tx_valid && rdy;
    frc  = 0;
    for (int c = 0; c < NCH; c++) if (m_pend[c] >= THR) frc = 1;
    fl   = !dl && free && frc;
    g_acc = tx_valid && tx_ready;

    if (m_ok) begin
      chk("link_valid", 64'(link_valid), 64'(m_vld));
      chk("tx_ready", 64'(tx_ready), 64'(rdy));
      for (int c = 0; c < NCH; c++) chk("credits_available", 64'(lane(c)), 64'(m_avail[c]));
      if (m_vld) begin
        chk("link_data", link_data, m_data);
        chk("link_chan", 64'(link_chan), 64'(m_chan));
        chk("link_credit", 64'(link_credit), 64'(m_cred));
        chk("link_credit_chan", 64'(link_credit_chan), 64'(m_cchan));
        chk("link_credit_only", 64'(link_credit_only), 64'(m_only));
      end
    end

    if (rst) begin
      model_reset();
      m_ok = 1;
    end else begin
      if (dl) begin
        m_vld = 1; m_data = tx_data; m_chan = tc; m_cred = cred; m_cchan = sel; m_only = 0;
        m_avail[tc]--; m_owed[tc]++;
      end else if (fl) begin
        m_vld = 1; m_data = '0; m_chan = 0; m_cred = cred; m_cchan = sel; m_only = 1;
      end else if (link_ready) begin
        m_vld = 0;
      end
      if (dl || fl) begin
        m_pend[sel] -= cred;
        if (cred != 0) m_rr = (sel + 1) % NCH;
      end
      for (int c = 0; c < NCH; c++) begin
        m_pend[c] += int'(rx_consume[c]);
        if (rx_credit_valid && int'(rx_credit_chan) == c) m_avail[c] += int'(rx_credit);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string name, input int cred, input int cchan, input bit only);
    chk({name, "_valid"}, 64'(link_valid), 64'd1);
    chk({name, "_credit"}, 64'(link_credit), 64'(cred));
    chk({name, "_credit_chan"}, 64'(link_credit_chan), 64'(cchan));
    chk({name, "_only"}, 64'(link_credit_only), 64'(only));
  endtask

  initial begin
    int acc;
    logic [63:0] pat;
    rst = 1; tx_data = '0; tx_chan = '0; tx_valid = 0; link_ready = 1;
    rx_credit = '0; rx_credit_chan = '0; rx_credit_valid = 0; rx_consume = '0;
    @(posedge clk); #1;
    step(); step();
    rst = 0;
    step();

    // Reset state
    chk("rst_valid", 64'(link_valid), 64'd0);
    chk("rst_ready", 64'(tx_ready), 64'd1);
    chk("rst_avail0", 64'(lane(0)), 64'd8);
    chk("rst_avail1", 64'(lane(1)), 64'd8);
    chk("rst_data", link_data, 64'd0);
    chk("rst_credit", 64'(link_credit), 64'd0);

    // Continuous ch0 traffic with no returns: seven beats, then last-credit stall
    tx_valid = 1; tx_chan = 0; tx_data = 64'h1111_0000_0000_0001;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      acc += int'(g_acc);
      tx_data = tx_data + 64'd1;
    end
    chk("burst_accepted", 64'(acc), 64'd7);
    chk("burst_stall_ready", 64'(g_acc), 64'd0);
    chk("burst_avail0", 64'(lane(0)), 64'd1);

    // One consume on ch1 unlocks the last ch0 credit
    rx_consume = 2'b10;
    step();
    rx_consume = 2'b00;
    step();
    chk("unlock_accept", 64'(g_acc), 64'd1);
    tx_valid = 0;
    chk_beat("unlock", 1, 1, 0);
    chk("unlock_chan", 64'(link_chan), 64'd0);
    chk("unlock_avail0", 64'(lane(0)), 64'd0);

    // Drain, then four ch0 consumes force a credit-only beat (held: link not ready)
    step();
    link_ready = 0;
    rx_consume = 2'b01;
    for (int i = 0; i < 4; i++) step();
    rx_consume = 2'b00;
    step();
    chk_beat("force", 4, 0, 1);
    chk("force_data", link_data, 64'd0);
    chk("force_chan", 64'(link_chan), 64'd0);

    // Held beat stays constant while consumes accumulate to pending={3,5}
    for (int i = 0; i < 5; i++) begin
      rx_consume = (i < 3) ? 2'b11 : 2'b10;
      step();
      chk_beat("hold", 4, 0, 1);
      chk("hold_data", link_data, 64'd0);
    end
    rx_consume = 2'b00;
    link_ready = 1;
    step();
    chk_beat("rr_first", 5, 1, 1);
    pat = 64'hDEAD_BEEF_0123_4567;
    tx_valid = 1; tx_chan = 1; tx_data = pat;
    step();
    chk_beat("rr_second", 3, 0, 0);
    chk("rr_second_data", link_data, pat);
    chk("rr_second_chan", 64'(link_chan), 64'd1);

    // Reset while a beat is stalled
    link_ready = 0; tx_data = 64'h5;
    step();
    step();
    chk("stall_valid", 64'(link_valid), 64'd1);
    rst = 1;
    step();
    chk("rst2_valid", 64'(link_valid), 64'd0);
    chk("rst2_avail0", 64'(lane(0)), 64'd8);
    chk("rst2_avail1", 64'(lane(1)), 64'd8);
    chk("rst2_ready", 64'(tx_ready), 64'd1);
    rst = 0; link_ready = 1; tx_chan = 0;
    step();
    chk_beat("rst2_beat", 0, 0, 0);
    tx_valid = 0;

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      tx_valid   = ($urandom_range(0, 99) < 60);
      tx_chan    = CHW'($urandom_range(0, NCH - 1));
      tx_data    = {$urandom, $urandom};
      link_ready = ($urandom_range(0, 99) < 70);
      rst        = ($urandom_range(0, 999) == 0);
      for (int c = 0; c < NCH; c++)
        rx_consume[c] = ($urandom_range(0, 99) < 25) && (m_pend[c] < NCRED);
      rx_credit_valid = 0; rx_credit = '0; rx_credit_chan = '0;
      if (!rst && $urandom_range(0, 99) < 30) begin
        int c;
        c = int'($urandom_range(0, NCH - 1));
        if (m_owed[c] > 0) begin
          int amt;
          amt = int'($urandom_range(1, m_owed[c]));
          m_owed[c] -= amt;
          rx_credit_valid = 1; rx_credit = CW'(amt); rx_credit_chan = CHW'(c);
        end
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
